// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side prediction, resolve-side update and statistics signals of the gshare predictor.
// The master drives branches in and the slave is the predictor itself.
interface gshare_branch_predictor_if #(
    parameter int HIST_BITS = 4
);
    logic                 pred_valid;
    logic [31:0]          pred_pc;
    logic                 take_branch;
    logic [HIST_BITS-1:0] pred_hist;

    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic [HIST_BITS-1:0] upd_hist;
    logic                 upd_taken;
    logic                 upd_mispredict;

    logic [HIST_BITS-1:0] ghr;
    logic [31:0]          branch_count;
    logic [31:0]          mispred_count;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
        input  take_branch, pred_hist, ghr, branch_count, mispred_count
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
        output take_branch, pred_hist, ghr, branch_count, mispred_count
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: saturating counters indexed by PC xor speculative global history.
// The history is restored from the returned snapshot when a branch resolves as mispredicted.
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int CTR_BITS   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    gshare_branch_predictor_if.slave bus
);
    localparam int                  DEPTH    = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0]   ctr_q [DEPTH];
    logic [HIST_BITS-1:0]  ghr_q;
    logic [HIST_BITS-1:0]  ghr_d;
    logic [31:0]           branch_count_q;
    logic [31:0]           branch_count_d;
    logic [31:0]           mispred_count_q;
    logic [31:0]           mispred_count_d;

    logic [INDEX_BITS-1:0] pidx;
    logic [INDEX_BITS-1:0] uidx;
    logic [CTR_BITS-1:0]   upd_ctr_old;
    logic [CTR_BITS-1:0]   upd_ctr_d;
    logic                  mispredict;
    logic                  unused_pc_bits;

    // History is narrower than or equal to the index, so the cast zero-extends it.
    assign pidx       = bus.pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign uidx       = bus.upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(bus.upd_hist);
    assign mispredict = bus.upd_valid & bus.upd_mispredict;

    assign unused_pc_bits = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0],
                              bus.upd_pc[31:INDEX_BITS+2], bus.upd_pc[1:0]};

    assign bus.take_branch   = ctr_q[pidx][CTR_BITS-1];
    assign bus.pred_hist     = ghr_q;
    assign bus.ghr           = ghr_q;
    assign bus.branch_count  = branch_count_q;
    assign bus.mispred_count = mispred_count_q;

    always_comb begin
        upd_ctr_old = ctr_q[uidx];
        upd_ctr_d   = upd_ctr_old;
        if (bus.upd_taken) begin
            if (upd_ctr_old != CTR_MAX) upd_ctr_d = upd_ctr_old + CTR_BITS'(1);
        end else begin
            if (upd_ctr_old != '0) upd_ctr_d = upd_ctr_old - CTR_BITS'(1);
        end
    end

    // A mispredict restore wins over a same-cycle fetch, which is on the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = HIST_BITS'({bus.upd_hist, bus.upd_taken});
        end else if (bus.pred_valid) begin
            ghr_d = HIST_BITS'({ghr_q, bus.take_branch});
        end
    end

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (bus.upd_valid && branch_count_q != '1) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict && mispred_count_q != '1) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_WEAK;
            end
            ghr_q           <= '0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (bus.upd_valid) begin
                ctr_q[uidx] <= upd_ctr_d;
            end
            ghr_q           <= ghr_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed and random stimulus for the gshare predictor, checked every cycle against
// an integer-arithmetic model of the counter table, history and statistics.
module tb_gshare_branch_predictor;
    localparam int INDEX_BITS = 6;
    localparam int HIST_BITS  = 4;
    localparam int CTR_BITS   = 2;
    localparam int DEPTH      = 64;
    localparam int CTR_TOP    = 3;
    localparam int CTR_HALF   = 2;
    localparam int HIST_MOD   = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int      mCtr [DEPTH];
    int      mGhr;
    longint  mBr;
    longint  mMis;

    gshare_branch_predictor_if #(.HIST_BITS(HIST_BITS)) bus ();

    gshare_branch_predictor #(
        .INDEX_BITS(INDEX_BITS),
        .HIST_BITS (HIST_BITS),
        .CTR_BITS  (CTR_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelIdx(input logic [31:0] pc, input int hist);
        return int'((pc / 4) % DEPTH) ^ hist;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic expTake;
        expTake = (mCtr[modelIdx(bus.pred_pc, mGhr)] >= CTR_HALF);
        checkVal("take_branch", 32'(bus.take_branch), 32'(expTake));
        checkVal("pred_hist", 32'(bus.pred_hist), 32'(mGhr));
        checkVal("ghr", 32'(bus.ghr), 32'(mGhr));
        checkVal("branch_count", bus.branch_count, 32'(mBr));
        checkVal("mispred_count", bus.mispred_count, 32'(mMis));
    endtask

    task automatic modelUpdate();
        int  u;
        bit  predTaken;
        predTaken = (mCtr[modelIdx(bus.pred_pc, mGhr)] >= CTR_HALF);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mCtr[i] = CTR_HALF;
            mGhr = 0;
            mBr  = 0;
            mMis = 0;
        end else begin
            if (bus.upd_valid) begin
                u = modelIdx(bus.upd_pc, int'(bus.upd_hist));
                if (bus.upd_taken) mCtr[u] = (mCtr[u] + 1 > CTR_TOP) ? CTR_TOP : mCtr[u] + 1;
                else               mCtr[u] = (mCtr[u] - 1 < 0) ? 0 : mCtr[u] - 1;
                if (mBr < 64'hFFFF_FFFF) mBr++;
                if (bus.upd_mispredict && mMis < 64'hFFFF_FFFF) mMis++;
            end
            if (bus.upd_valid && bus.upd_mispredict)
                mGhr = (int'(bus.upd_hist) * 2 + int'(bus.upd_taken)) % HIST_MOD;
            else if (bus.pred_valid)
                mGhr = (mGhr * 2 + int'(predTaken)) % HIST_MOD;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit pv, input logic [31:0] ppc,
                                 input bit uv, input logic [31:0] upc, input logic [3:0] uh,
                                 input bit ut, input bit um);
        @(negedge clk);
        rst                = r;
        bus.pred_valid     = pv;
        bus.pred_pc        = ppc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_hist       = uh;
        bus.upd_taken      = ut;
        bus.upd_mispredict = um;
    endtask

    task automatic runCycle(input bit r, input bit pv, input logic [31:0] ppc,
                            input bit uv, input logic [31:0] upc, input logic [3:0] uh,
                            input bit ut, input bit um);
        applyStimulus(r, pv, ppc, uv, upc, uh, ut, um);
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
    endtask

    // Idle inputs with a chosen fetch PC; the following edge changes no state.
    task automatic probe(input logic [31:0] pc);
        applyStimulus(1'b0, 1'b0, pc, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        checkOutput();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) mCtr[i] = 0;
        mGhr = 0;
        mBr  = 0;
        mMis = 0;
        rst  = 1'b1;
        bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
        bus.upd_hist = '0; bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b0;

        // Reset state
        @(posedge clk);
        modelUpdate();
        runCycle(1, 0, 32'h40, 0, 32'h0, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("rst_take", 32'(bus.take_branch), 32'd1);
        checkVal("rst_hist", 32'(bus.pred_hist), 32'd0);
        checkVal("rst_brcount", bus.branch_count, 32'd0);

        // Train down, then saturate at both ends
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("train1_take", 32'(bus.take_branch), 32'd0);
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("train2_brcount", bus.branch_count, 32'd2);
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("sat_low_take", 32'(bus.take_branch), 32'd0);
        for (int i = 0; i < 4; i++) runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 1, 0);
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("sat_high_take", 32'(bus.take_branch), 32'd1);

        // Speculative shift then mispredict recovery with a squashed same-cycle fetch
        runCycle(1, 0, 32'h40, 0, 32'h0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) runCycle(0, 1, 32'h40, 0, 32'h0, 4'h0, 0, 0);
        probe(32'h40);
        checkVal("spec_ghr", 32'(bus.ghr), 32'h7);
        runCycle(0, 1, 32'h40, 1, 32'h80, 4'b0001, 0, 1);
        probe(32'h40);
        checkVal("recover_ghr", 32'(bus.ghr), 32'h2);
        checkVal("recover_mis", bus.mispred_count, 32'd1);

        // Aliasing: 0x44 with history 0001 hits the entry trained by 0x40 with history 0
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        runCycle(0, 0, 32'h40, 1, 32'h40, 4'h0, 0, 0);
        runCycle(0, 0, 32'h40, 1, 32'h100, 4'h0, 1, 1);
        probe(32'h44);
        checkVal("alias_ghr", 32'(bus.ghr), 32'h1);
        checkVal("alias_take", 32'(bus.take_branch), 32'd0);

        // Reset in the middle of activity
        runCycle(1, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0);
        for (int i = 0; i < 5; i++) runCycle(0, 0, 32'h0, 1, 32'(i * 4), 4'(i), 0, 1);
        probe(32'h0);
        checkVal("pre_rst_br", bus.branch_count, 32'd5);
        checkVal("pre_rst_mis", bus.mispred_count, 32'd5);
        runCycle(1, 1, 32'h0, 1, 32'h0, 4'h3, 0, 1);
        probe(32'h0);
        checkVal("midrst_take0", 32'(bus.take_branch), 32'd1);
        checkVal("midrst_ghr", 32'(bus.ghr), 32'd0);
        checkVal("midrst_br", bus.branch_count, 32'd0);
        checkVal("midrst_mis", bus.mispred_count, 32'd0);
        probe(32'h8);
        checkVal("midrst_take8", 32'(bus.take_branch), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            runCycle($urandom_range(0, 59) == 0,
                     1'($urandom),
                     $urandom & 32'h0000_00FF,
                     1'($urandom),
                     $urandom & 32'h0000_00FF,
                     4'($urandom),
                     1'($urandom),
                     $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Parametrised gshare direction predictor replacing the per-set signed-counter predictor. A table of 2^INDEX_BITS saturating counters is indexed by PC XOR global history. The block keeps a speculative global history register (GHR) and supports checkpoint/restore on mispredict. It sits between fetch (prediction port) and execute/branch resolution (update port), and also provides resolved-branch and mispredict statistics.

Parameters:
INDEX_BITS, 6, log2 of counter table depth; index taken from pc[INDEX_BITS+1:2]
HIST_BITS, 4, GHR width; must be >= 1 and <= INDEX_BITS
CTR_BITS, 2, saturating counter width; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_valid  in  1  fetch presents a branch this cycle; GHR shifts speculatively
pred_pc  in  32  PC of fetched branch
take_branch  out  1  predicted direction for pred_pc (combinational)
pred_hist  out  HIST_BITS  GHR snapshot used for this prediction; carried down pipe with the branch
upd_valid  in  1  branch resolved this cycle
upd_pc  in  32  PC of resolved branch
upd_hist  in  HIST_BITS  pred_hist snapshot returned with the branch
upd_taken  in  1  actual direction
upd_mispredict  in  1  resolved direction differed from prediction; qualified by upd_valid
ghr  out  HIST_BITS  current speculative GHR
branch_count  out  32  resolved branches since reset
mispred_count  out  32  mispredicts since reset

Behaviour:
- Reset, synchronous on rst=1 at posedge: every counter = 2^(CTR_BITS-1) (weakly taken); GHR = 0; branch_count = mispred_count = 0. rst overrides all same-cycle pred/upd activity. Post-reset, take_branch=1 and pred_hist=0 for any PC.
- Prediction index: pidx = pred_pc[INDEX_BITS+1:2] XOR zero-extend(GHR). take_branch = MSB of counter[pidx]. pred_hist = GHR. Both are combinational, with zero latency.
- Update index: uidx = upd_pc[INDEX_BITS+1:2] XOR zero-extend(upd_hist). No tags; aliasing is allowed.
- Counter update, at posedge when upd_valid=1: upd_taken=1 increments, saturating at 2^CTR_BITS-1. upd_taken=0 decrements, saturating at 0. No wrap in either direction.
- Same-cycle read/write to the same index: the prediction sees the pre-update value. The write lands at the clock edge.
- GHR next-state, in priority order:
  1. rst -> 0.
  2. upd_valid & upd_mispredict -> {upd_hist[HIST_BITS-2:0], upd_taken}. When HIST_BITS=1, this is upd_taken. A same-cycle pred_valid is treated as a squashed wrong-path fetch and does not shift.
  3. pred_valid -> {GHR[HIST_BITS-2:0], take_branch}.
  4. Otherwise hold.
- upd_valid without mispredict never alters GHR; the speculative value is already correct.
- Statistics: branch_count += 1 on each upd_valid. mispred_count += 1 on upd_valid & upd_mispredict. Both saturate at 32'hFFFFFFFF and do not wrap.
- upd_mispredict while upd_valid=0 is ignored.
- No internal state machine beyond the table, GHR and counters. No stalls; the block is always ready on both ports.

Test Plan:
(Defaults INDEX_BITS=6, HIST_BITS=4, CTR_BITS=2.)
- Reset: assert rst 1 cycle, then pred_pc=0x40, pred_valid=0 -> take_branch=1, pred_hist=4'h0, ghr=0, both stat counters 0.
- Train down: pred_valid=0; upd_pc=0x40, upd_hist=0, upd_taken=0, upd_valid for 2 cycles -> counter[0x10] goes 2->1->0; take_branch for pred_pc=0x40 becomes 0 after the 1st update; branch_count=2.
- Saturation: from counter[0x10]=0, apply a 3rd not-taken -> stays 0. Then 4 taken updates -> 3 (saturated). Then 1 not-taken -> 2, take_branch still 1.
- Speculative shift and recovery: after reset, pred_valid 3 cycles with take_branch=1 -> ghr=4'b0111. Then upd_valid=1, upd_mispredict=1, upd_hist=4'b0001, upd_taken=0, with pred_valid=1 in the same cycle -> ghr=4'b0010 next cycle; mispred_count=1.
- Hash aliasing: train upd_pc=0x40, upd_hist=0 to counter 0. Then, with GHR forced to 4'b0001 via mispredict restore, pred_pc=0x44 -> index 6'b010001^6'b000001=0x10 -> take_branch=0.
- Reset mid-operation: with a trained table and stats counters at 5, assert rst together with upd_valid, upd_mispredict and pred_valid -> next cycle all counters are weakly taken, ghr=0, stats=0.
